// File: rtl/decode_pipe_stage.sv
// Instruction decode stage: turns a fetched RV32 instruction into the registered ID/EX bundle,
// with optional write-back forwarding and an EMPTY/FULL handshake supporting stall and flush.
module decode_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   inst_addr,
    input  logic              inst_valid,
    output logic              id_ready,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_inst,
    output logic [XLEN-1:0]   ex_inst_addr,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_wen,
    output logic              ex_illegal
);
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam bit         FWD       = (BYPASS_EN != 0);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1_a, rs2_a, rd_d;
    logic [31:0]       imm32;
    logic              wen_d, ill_d;
    logic [XLEN-1:0]   op1_d, op2_d, imm_d;

    logic [31:0]       inst_q;
    logic [XLEN-1:0]   addr_q, op1_q, op2_q, imm_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q, ill_q;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        rs1_a = '0;
        rs2_a = '0;
        rd_d  = '0;
        imm32 = '0;
        wen_d = 1'b0;
        ill_d = 1'b0;
        case (opcode)
            OP_IMM, OP_JALR: begin
                if (opcode == OP_IMM || funct3 == 3'b000) begin
                    rs1_a = REG_AW'(inst[19:15]);
                    rd_d  = REG_AW'(inst[11:7]);
                    wen_d = 1'b1;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    ill_d = 1'b1;
                end
            end
            OP_REG: begin
                rs1_a = REG_AW'(inst[19:15]);
                rs2_a = REG_AW'(inst[24:20]);
                rd_d  = REG_AW'(inst[11:7]);
                wen_d = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    rs1_a = REG_AW'(inst[19:15]);
                    rs2_a = REG_AW'(inst[24:20]);
                    imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                end else begin
                    ill_d = 1'b1;
                end
            end
            OP_JAL: begin
                rd_d  = REG_AW'(inst[11:7]);
                wen_d = 1'b1;
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                rd_d  = REG_AW'(inst[11:7]);
                wen_d = 1'b1;
                imm32 = {inst[31:12], 12'b0};
            end
            default: ill_d = 1'b1;
        endcase
    end

    assign imm_d    = XLEN'($signed(imm32));
    assign rs1_addr = rs1_a;
    assign rs2_addr = rs2_a;

    // A zero address yields zero, which also keeps x0 writes from being forwarded.
    always_comb begin
        op1_d = '0;
        op2_d = '0;
        if (rs1_a != '0) op1_d = (FWD && wb_wen && wb_addr == rs1_a) ? wb_data : rs1_data_in;
        if (rs2_a != '0) op2_d = (FWD && wb_wen && wb_addr == rs2_a) ? wb_data : rs2_data_in;
    end

    assign id_ready = (state_q == EMPTY || ex_ready) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            inst_q  <= '0;
            addr_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
            wen_q   <= 1'b0;
        end else if (id_ready) begin
            if (inst_valid) begin
                state_q <= FULL;
                inst_q  <= inst;
                addr_q  <= inst_addr;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                imm_q   <= imm_d;
                rd_q    <= rd_d;
                wen_q   <= wen_d;
                ill_q   <= ill_d;
            end else begin
                state_q <= EMPTY;
                wen_q   <= 1'b0;
            end
        end
    end

    assign ex_valid     = (state_q == FULL);
    assign ex_inst      = inst_q;
    assign ex_inst_addr = addr_q;
    assign ex_op1       = op1_q;
    assign ex_op2       = op2_q;
    assign ex_imm       = imm_q;
    assign ex_rd_addr   = rd_q;
    assign ex_rd_wen    = wen_q;
    assign ex_illegal   = ill_q;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: directed vectors push expected bundles, a negedge
// monitor pops and compares on each ex_valid && ex_ready; a second instance has forwarding off.
module tb_decode_pipe_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0, inst_addr = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] rs1_data_in = '0, rs2_data_in = '0, wb_data = '0;
    logic        wb_wen = 1'b0, ex_ready = 1'b1, flush = 1'b0;
    logic [4:0]  wb_addr = '0;

    logic        id_ready, ex_valid, ex_rd_wen, ex_illegal;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd_addr;
    logic [31:0] ex_inst, ex_inst_addr, ex_op1, ex_op2, ex_imm;

    logic        id_ready_n, ex_valid_n, ex_rd_wen_n, ex_illegal_n;
    logic [4:0]  rs1_addr_n, rs2_addr_n, ex_rd_addr_n;
    logic [31:0] ex_inst_n, ex_inst_addr_n, ex_op1_n, ex_op2_n, ex_imm_n;

    always #5 clk = ~clk;

    decode_pipe_stage #(.XLEN(32), .REG_AW(5), .BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_addr(inst_addr), .inst_valid(inst_valid),
        .id_ready(id_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_inst(ex_inst),
        .ex_inst_addr(ex_inst_addr), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_illegal(ex_illegal));

    decode_pipe_stage #(.XLEN(32), .REG_AW(5), .BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst(rst), .inst(inst), .inst_addr(inst_addr), .inst_valid(inst_valid),
        .id_ready(id_ready_n), .rs1_addr(rs1_addr_n), .rs2_addr(rs2_addr_n),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid_n), .ex_inst(ex_inst_n),
        .ex_inst_addr(ex_inst_addr_n), .ex_op1(ex_op1_n), .ex_op2(ex_op2_n), .ex_imm(ex_imm_n),
        .ex_rd_addr(ex_rd_addr_n), .ex_rd_wen(ex_rd_wen_n), .ex_illegal(ex_illegal_n));

    typedef struct {
        logic [31:0] inst, addr, op1, op2, imm;
        logic [4:0]  rd;
        logic        wen, ill;
        logic [31:0] op1n, op2n;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc = 32'h0000_1000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] op1, op2, imm, input logic [4:0] rd,
                                input logic wen, ill, input logic [31:0] op1n, op2n);
        exp_t e;
        e.inst = '0; e.addr = '0;
        e.op1 = op1; e.op2 = op2; e.imm = imm; e.rd = rd;
        e.wen = wen; e.ill = ill; e.op1n = op1n; e.op2n = op2n;
        return e;
    endfunction

    task automatic issue(input bit wait_edge, input logic [31:0] i, d1, d2, input logic ww,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, a2, input exp_t e);
        if (wait_edge) begin
            @(posedge clk);
            #1;
        end
        inst = i; inst_addr = pc; inst_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
        rs1_data_in = d1; rs2_data_in = d2; wb_wen = ww; wb_addr = wa; wb_data = wd;
        e.inst = i; e.addr = pc;
        sb.push_back(e);
        pc = pc + 32'd4;
        #1;
        chk("rs1_addr", 32'(rs1_addr), 32'(a1));
        chk("rs2_addr", 32'(rs2_addr), 32'(a2));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        inst_valid = 1'b0; wb_wen = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 0);
        chk({tag, "_inst"}, ex_inst, 0);
        chk({tag, "_addr"}, ex_inst_addr, 0);
        chk({tag, "_op1"}, ex_op1, 0);
        chk({tag, "_op2"}, ex_op2, 0);
        chk({tag, "_imm"}, ex_imm, 0);
        chk({tag, "_rd"}, 32'(ex_rd_addr), 0);
        chk({tag, "_wen"}, 32'(ex_rd_wen), 0);
        chk({tag, "_ill"}, 32'(ex_illegal), 0);
    endtask

    // Monitor: one transfer per cycle where the bundle is valid and execute accepts it.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h expected=none", ex_inst);
            end else begin
                e = sb.pop_front();
                chk("mon_inst", ex_inst, e.inst);
                chk("mon_addr", ex_inst_addr, e.addr);
                chk("mon_op1", ex_op1, e.op1);
                chk("mon_op2", ex_op2, e.op2);
                chk("mon_imm", ex_imm, e.imm);
                chk("mon_rd", 32'(ex_rd_addr), 32'(e.rd));
                chk("mon_wen", 32'(ex_rd_wen), 32'(e.wen));
                chk("mon_ill", 32'(ex_illegal), 32'(e.ill));
                chk("mon_nb_valid", 32'(ex_valid_n), 1);
                chk("mon_nb_op1", ex_op1_n, e.op1n);
                chk("mon_nb_op2", ex_op2_n, e.op2n);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_zero("rst");
        chk("rst_id_ready", 32'(id_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        issue(1, 32'h00510093, 32'd10, 32'h77, 0, 5'd0, 0, 5'd2, 5'd0, mk(10, 0, 5, 1, 1, 0, 10, 0));
        issue(1, 32'h002101B3, 32'h11, 32'h22, 1, 5'd2, 32'h55, 5'd2, 5'd2,
              mk(32'h55, 32'h55, 0, 3, 1, 0, 32'h11, 32'h22));
        issue(1, 32'h002101B3, 32'h11, 32'h22, 1, 5'd0, 32'h55, 5'd2, 5'd2,
              mk(32'h11, 32'h22, 0, 3, 1, 0, 32'h11, 32'h22));
        issue(1, 32'h004101B3, 32'h11, 32'h22, 1, 5'd4, 32'h99, 5'd2, 5'd4,
              mk(32'h11, 32'h99, 0, 3, 1, 0, 32'h11, 32'h22));
        issue(1, 32'h404101B3, 32'h11, 32'h22, 1, 5'd2, 32'h55, 5'd2, 5'd4,
              mk(32'h55, 32'h22, 0, 3, 1, 0, 32'h11, 32'h22));
        issue(1, 32'h000002B3, 32'hAA, 32'hBB, 1, 5'd0, 32'h55, 5'd0, 5'd0, mk(0, 0, 0, 5, 1, 0, 0, 0));
        issue(1, 32'hFFFFFFFF, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 1, 0, 0));
        issue(1, 32'h0000006F, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 0, 0, 1, 0, 0, 0));
        issue(1, 32'hFE208EE3, 32'h11, 32'h22, 0, 5'd0, 0, 5'd1, 5'd2,
              mk(32'h11, 32'h22, 32'hFFFFFFFC, 0, 0, 0, 32'h11, 32'h22));
        issue(1, 32'hFE20AEE3, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 1, 0, 0));
        issue(1, 32'h123453B7, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 32'h12345000, 7, 1, 0, 0, 0));
        issue(1, 32'hFFFFF417, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 32'hFFFFF000, 8, 1, 0, 0, 0));
        issue(1, 32'hFF8280E7, 32'h11, 32'h22, 0, 5'd0, 0, 5'd5, 5'd0,
              mk(32'h11, 0, 32'hFFFFFFF8, 1, 1, 0, 32'h11, 0));
        issue(1, 32'hFF8290E7, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 1, 0, 0));
        issue(1, 32'h008000EF, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 8, 1, 1, 0, 0, 0));
        issue(1, 32'hFFF17093, 32'h11, 32'h22, 0, 5'd0, 0, 5'd2, 5'd0,
              mk(32'h11, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h11, 0));
        idle();
        @(posedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(ex_valid), 0);

        // Stall: three cycles of back-pressure with a changing instruction at the input.
        issue(1, 32'h00510093, 32'd10, 32'h77, 0, 5'd0, 0, 5'd2, 5'd0, mk(10, 0, 5, 1, 1, 0, 10, 0));
        @(posedge clk);
        #1;
        ex_ready = 1'b0; inst = 32'h002101B3; rs1_data_in = 32'd99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_id_ready", 32'(id_ready), 0);
            chk("stall_valid", 32'(ex_valid), 1);
            chk("stall_inst", ex_inst, 32'h00510093);
            chk("stall_op1", ex_op1, 32'd10);
            chk("stall_imm", ex_imm, 32'd5);
            chk("stall_rd", 32'(ex_rd_addr), 1);
            @(posedge clk);
            #1;
            inst = inst + 32'h0010_0000;
        end
        issue(0, 32'h002101B3, 32'h11, 32'h22, 0, 5'd0, 0, 5'd2, 5'd2,
              mk(32'h11, 32'h22, 0, 3, 1, 0, 32'h11, 32'h22));
        idle();

        // Flush with a concurrent valid instruction: the new one is dropped, the stage empties.
        issue(1, 32'h00510093, 32'd10, 32'h77, 0, 5'd0, 0, 5'd2, 5'd0, mk(10, 0, 5, 1, 1, 0, 10, 0));
        @(posedge clk);
        #1;
        flush = 1'b1; inst = 32'h123453B7; inst_valid = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", 32'(id_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0; inst_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_wen", 32'(ex_rd_wen), 0);
        chk("flush_nb_valid", 32'(ex_valid_n), 0);

        // Asynchronous reset between edges while stalled, then load on the first edge after release.
        issue(1, 32'h008000EF, 32'h11, 32'h22, 0, 5'd0, 0, 5'd0, 5'd0, mk(0, 0, 8, 1, 1, 0, 0, 0));
        @(posedge clk);
        #1;
        ex_ready = 1'b0; inst_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        sb.delete();
        #1;
        rst = 1'b0;
        issue(0, 32'hFFF17093, 32'h11, 32'h22, 0, 5'd0, 0, 5'd2, 5'd0,
              mk(32'h11, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h11, 0));
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(ex_valid), 1);
        chk("post_rst_inst", ex_inst, 32'hFFF17093);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
